// File: rtl/reset_sequencer.sv
// Synchronised-button / PLL-lock reset generator releasing NUM_DOMAINS resets in staggered order.
// Button-to-assert latency SYNC_STAGES+1 edges; optional cause register under RESET_SEQ_CAUSE_EN.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   btn,
  input  logic                   pll_lock,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             cause
);

  localparam int IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int LAST_IDX = (NUM_DOMAINS > 1) ? NUM_DOMAINS - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   trigger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge only, so a held button yields a single trigger.
  assign trigger = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!pll_lock || trigger) begin
        state   <= S_HOLD;
        cnt     <= '0;
        idx     <= '0;
        rst_out <= '1;
        busy    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            rst_out <= '0;
            busy    <= 1'b0;
          end
          S_HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              cnt <= '0;
              idx <= '0;
              if (NUM_DOMAINS == 1) begin
                state   <= S_IDLE;
                rst_out <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state   <= S_RELEASE;
                rst_out <= rst_out << 1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            // Left shift clears the lowest still-asserted domain, keeping higher bits set.
            if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
              cnt     <= '0;
              rst_out <= rst_out << 1;
              idx     <= idx + 1'b1;
              if (idx == IDX_W'(LAST_IDX)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= S_HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef RESET_SEQ_CAUSE_EN
  // Lock loss is tested first so it wins over a simultaneous button edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause <= 2'b11;
    end else if (state != S_HOLD) begin
      if (!pll_lock)
        cause <= 2'b10;
      else if (trigger)
        cause <= 2'b01;
    end
  end
`else
  assign cause = 2'b00;
`endif

endmodule
